// File: rtl/pin_entry_controller_if.sv
// rtl/pin_entry_controller_if.sv - keypad/card inputs and PIN status outputs of pin_entry_controller
interface pin_entry_controller_if;
  logic       card_present;
  logic       key_valid;
  logic [3:0] key_code;
  logic       pin_valid;
  logic       pin_ok;
  logic       pin_bad;
  logic       pin_locked;
  logic [1:0] attempt;
  logic [2:0] digit_count;
  logic       busy;

  modport master (
    output card_present, key_valid, key_code,
    input  pin_valid, pin_ok, pin_bad, pin_locked, attempt, digit_count, busy
  );

  modport slave (
    input  card_present, key_valid, key_code,
    output pin_valid, pin_ok, pin_bad, pin_locked, attempt, digit_count, busy
  );
endinterface

// File: rtl/pin_entry_controller.sv
// rtl/pin_entry_controller.sv - keypad PIN collection, check, attempt counting and timed lockout
module pin_entry_controller #(
  parameter int          PIN_DIGITS     = 4,
  parameter logic [15:0] STORED_PIN     = 16'h1234,
  parameter int          MAX_ATTEMPTS   = 3,
  parameter int          LOCK_CYCLES    = 1000,
  parameter int          TIMEOUT_CYCLES = 200
) (
  input logic clk,
  input logic reset,
  pin_entry_controller_if.slave bus
);

  localparam int TMAX = (LOCK_CYCLES > TIMEOUT_CYCLES) ? LOCK_CYCLES : TIMEOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0]             LOCK_LAST = TW'(LOCK_CYCLES - 1);
  localparam logic [TW-1:0]             TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]                FULL      = 3'(PIN_DIGITS);
  localparam logic [1:0]                MAX_ATT   = 2'(MAX_ATTEMPTS);
  localparam logic [4*PIN_DIGITS-1:0]   PIN_REF   = STORED_PIN[4*PIN_DIGITS-1:0];

  typedef enum logic [2:0] {IDLE, COLLECT, CHECK, GRANT, LOCKED} state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_buf [PIN_DIGITS];
  logic [3:0]      w_buf_nxt [PIN_DIGITS];
  logic [2:0]      r_count, w_count_nxt;
  logic [1:0]      r_attempt, w_attempt_nxt;
  logic [TW-1:0]   r_timer, w_timer_nxt;
  logic            w_ok_nxt, w_bad_nxt;
  logic [4*PIN_DIGITS-1:0] w_packed;
  logic [1:0]      w_att_inc;
  logic            r_pin_valid, r_pin_ok, r_pin_bad, r_pin_locked, r_busy;

  // r_buf[0] holds the newest digit, so the first digit ends up most significant
  always_comb begin
    w_packed = '0;
    for (int i = 0; i < PIN_DIGITS; i++) w_packed[4*i +: 4] = r_buf[i];
  end

  assign w_att_inc = r_attempt + 2'd1;

  always_comb begin
    w_state_nxt   = r_state;
    w_buf_nxt     = r_buf;
    w_count_nxt   = r_count;
    w_attempt_nxt = r_attempt;
    w_timer_nxt   = r_timer;
    w_ok_nxt      = 1'b0;
    w_bad_nxt     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.card_present) begin
          w_state_nxt = COLLECT;
          for (int i = 0; i < PIN_DIGITS; i++) w_buf_nxt[i] = 4'd0;
          w_count_nxt = 3'd0;
          w_timer_nxt = '0;
        end
      end
      COLLECT: begin
        if (!bus.card_present) begin
          w_state_nxt = IDLE;
          for (int i = 0; i < PIN_DIGITS; i++) w_buf_nxt[i] = 4'd0;
          w_count_nxt   = 3'd0;
          w_attempt_nxt = 2'd0;
          w_timer_nxt   = '0;
        end else if (bus.key_valid) begin
          w_timer_nxt = '0;
          if (bus.key_code <= 4'd9) begin
            if (r_count < FULL) begin
              for (int i = PIN_DIGITS - 1; i > 0; i--) w_buf_nxt[i] = r_buf[i-1];
              w_buf_nxt[0] = bus.key_code;
              w_count_nxt  = r_count + 3'd1;
            end
          end else if (bus.key_code == 4'hA) begin
            for (int i = 0; i < PIN_DIGITS; i++) w_buf_nxt[i] = 4'd0;
            w_count_nxt = 3'd0;
          end else if (bus.key_code == 4'hB && r_count == FULL) begin
            w_state_nxt = CHECK;
          end
        end else if (r_timer == TO_LAST) begin
          for (int i = 0; i < PIN_DIGITS; i++) w_buf_nxt[i] = 4'd0;
          w_count_nxt = 3'd0;
          w_timer_nxt = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      CHECK: begin
        if (!bus.card_present) begin
          w_state_nxt = IDLE;
          for (int i = 0; i < PIN_DIGITS; i++) w_buf_nxt[i] = 4'd0;
          w_count_nxt   = 3'd0;
          w_attempt_nxt = 2'd0;
        end else if (w_packed == PIN_REF) begin
          w_state_nxt   = GRANT;
          w_ok_nxt      = 1'b1;
          w_attempt_nxt = 2'd0;
        end else begin
          w_bad_nxt     = 1'b1;
          w_attempt_nxt = w_att_inc;
          w_state_nxt   = (w_att_inc == MAX_ATT) ? LOCKED : COLLECT;
          for (int i = 0; i < PIN_DIGITS; i++) w_buf_nxt[i] = 4'd0;
          w_count_nxt = 3'd0;
        end
        w_timer_nxt = '0;
      end
      GRANT: begin
        if (!bus.card_present) begin
          w_state_nxt = IDLE;
          for (int i = 0; i < PIN_DIGITS; i++) w_buf_nxt[i] = 4'd0;
          w_count_nxt   = 3'd0;
          w_attempt_nxt = 2'd0;
        end
      end
      LOCKED: begin
        // lockout runs to completion regardless of the card
        if (r_timer == LOCK_LAST) begin
          w_state_nxt   = IDLE;
          w_attempt_nxt = 2'd0;
          w_timer_nxt   = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      for (int i = 0; i < PIN_DIGITS; i++) r_buf[i] <= 4'd0;
      r_count      <= 3'd0;
      r_attempt    <= 2'd0;
      r_timer      <= '0;
      r_pin_valid  <= 1'b0;
      r_pin_ok     <= 1'b0;
      r_pin_bad    <= 1'b0;
      r_pin_locked <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_buf        <= w_buf_nxt;
      r_count      <= w_count_nxt;
      r_attempt    <= w_attempt_nxt;
      r_timer      <= w_timer_nxt;
      r_pin_valid  <= (w_state_nxt == GRANT);
      r_pin_ok     <= w_ok_nxt;
      r_pin_bad    <= w_bad_nxt;
      r_pin_locked <= (w_state_nxt == LOCKED);
      r_busy       <= (w_state_nxt == COLLECT) || (w_state_nxt == CHECK);
    end
  end

  assign bus.pin_valid   = r_pin_valid;
  assign bus.pin_ok      = r_pin_ok;
  assign bus.pin_bad     = r_pin_bad;
  assign bus.pin_locked  = r_pin_locked;
  assign bus.attempt     = r_attempt;
  assign bus.digit_count = r_count;
  assign bus.busy        = r_busy;

endmodule

// File: tb/tb_pin_entry_controller.sv
// tb/tb_pin_entry_controller.sv - directed self-checking bench for pin_entry_controller
module tb_pin_entry_controller;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  pin_entry_controller_if bus ();

  pin_entry_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] code);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    tick(1);
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"},  {15'd0, bus.pin_valid}, 16'd0);
    chk({tag, "_ok"},     {15'd0, bus.pin_ok}, 16'd0);
    chk({tag, "_bad"},    {15'd0, bus.pin_bad}, 16'd0);
    chk({tag, "_locked"}, {15'd0, bus.pin_locked}, 16'd0);
    chk({tag, "_att"},    {14'd0, bus.attempt}, 16'd0);
    chk({tag, "_cnt"},    {13'd0, bus.digit_count}, 16'd0);
    chk({tag, "_busy"},   {15'd0, bus.busy}, 16'd0);
  endtask

  task automatic enter_pin(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
    key(a); key(b); key(c); key(d); key(4'hB);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    bus.card_present = 1'b0;
    bus.key_valid    = 1'b0;
    bus.key_code     = 4'h0;
    tick(3);
    chk_all_zero("reset");
    reset = 1'b1;
    tick(2);
    chk("idle_busy", {15'd0, bus.busy}, 16'd0);

    // 1: correct PIN, grant, card out
    bus.card_present = 1'b1;
    tick(1);
    chk("t1_busy", {15'd0, bus.busy}, 16'd1);
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    chk("t1_cnt", {13'd0, bus.digit_count}, 16'd4);
    key(4'hB);
    chk("t1_ok_early", {15'd0, bus.pin_ok}, 16'd0);
    chk("t1_check_busy", {15'd0, bus.busy}, 16'd1);
    tick(1);
    chk("t1_ok", {15'd0, bus.pin_ok}, 16'd1);
    chk("t1_valid", {15'd0, bus.pin_valid}, 16'd1);
    chk("t1_att", {14'd0, bus.attempt}, 16'd0);
    chk("t1_busy_grant", {15'd0, bus.busy}, 16'd0);
    tick(1);
    chk("t1_ok_pulse", {15'd0, bus.pin_ok}, 16'd0);
    chk("t1_valid_hold", {15'd0, bus.pin_valid}, 16'd1);
    key(4'd7);
    chk("t1_grant_keys", {13'd0, bus.digit_count}, 16'd4);
    bus.card_present = 1'b0;
    tick(1);
    chk("t1_valid_off", {15'd0, bus.pin_valid}, 16'd0);

    // 2: wrong then right
    bus.card_present = 1'b1;
    tick(1);
    enter_pin(4'd1, 4'd2, 4'd3, 4'd5);
    tick(1);
    chk("t2_bad", {15'd0, bus.pin_bad}, 16'd1);
    chk("t2_att1", {14'd0, bus.attempt}, 16'd1);
    chk("t2_ok0", {15'd0, bus.pin_ok}, 16'd0);
    chk("t2_cnt0", {13'd0, bus.digit_count}, 16'd0);
    tick(1);
    chk("t2_bad_pulse", {15'd0, bus.pin_bad}, 16'd0);
    enter_pin(4'd1, 4'd2, 4'd3, 4'd4);
    tick(1);
    chk("t2_ok", {15'd0, bus.pin_ok}, 16'd1);
    chk("t2_att0", {14'd0, bus.attempt}, 16'd0);
    bus.card_present = 1'b0;
    tick(1);

    // 3: three failures lock, card cycling does not release
    bus.card_present = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      enter_pin(4'd9, 4'd9, 4'd9, 4'd9);
      tick(1);
      chk("t3_bad", {15'd0, bus.pin_bad}, 16'd1);
      chk("t3_att", {14'd0, bus.attempt}, 16'(i + 1));
      chk("t3_locked", {15'd0, bus.pin_locked}, (i == 2) ? 16'd1 : 16'd0);
    end
    bus.card_present = 1'b0;
    tick(5);
    bus.card_present = 1'b1;
    key(4'd1);
    tick(979);
    chk("t3_still_locked", {15'd0, bus.pin_locked}, 16'd1);
    chk("t3_locked_cnt", {13'd0, bus.digit_count}, 16'd0);
    tick(20);
    chk("t3_unlocked", {15'd0, bus.pin_locked}, 16'd0);
    chk("t3_att_clr", {14'd0, bus.attempt}, 16'd0);
    chk("t3_recollect", {15'd0, bus.busy}, 16'd1);

    // 4: clear, overflow digit ignored, short enter ignored
    key(4'd1); key(4'd2);
    chk("t4_cnt2", {13'd0, bus.digit_count}, 16'd2);
    key(4'hA);
    chk("t4_clear", {13'd0, bus.digit_count}, 16'd0);
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd9);
    chk("t4_cnt_sat", {13'd0, bus.digit_count}, 16'd4);
    key(4'hB);
    tick(1);
    chk("t4_ok", {15'd0, bus.pin_ok}, 16'd1);
    bus.card_present = 1'b0;
    tick(1);
    bus.card_present = 1'b1;
    tick(1);
    key(4'd1); key(4'd2); key(4'd3); key(4'hB);
    tick(2);
    chk("t4_short_ok", {15'd0, bus.pin_ok}, 16'd0);
    chk("t4_short_bad", {15'd0, bus.pin_bad}, 16'd0);
    chk("t4_short_busy", {15'd0, bus.busy}, 16'd1);
    chk("t4_short_cnt", {13'd0, bus.digit_count}, 16'd3);
    key(4'hE);
    chk("t4_unsup", {13'd0, bus.digit_count}, 16'd3);

    // 5: inactivity timeout keeps attempt
    key(4'hA);
    enter_pin(4'd5, 4'd5, 4'd5, 4'd5);
    tick(1);
    chk("t5_att1", {14'd0, bus.attempt}, 16'd1);
    key(4'd1); key(4'd2);
    tick(190);
    chk("t5_before", {13'd0, bus.digit_count}, 16'd2);
    tick(15);
    chk("t5_after", {13'd0, bus.digit_count}, 16'd0);
    chk("t5_att_kept", {14'd0, bus.attempt}, 16'd1);
    chk("t5_busy", {15'd0, bus.busy}, 16'd1);

    // 6: card out with enter, then reset mid-lockout
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    bus.card_present = 1'b0;
    key(4'hB);
    chk("t6_idle_busy", {15'd0, bus.busy}, 16'd0);
    chk("t6_att_clr", {14'd0, bus.attempt}, 16'd0);
    tick(1);
    chk("t6_no_ok", {15'd0, bus.pin_ok}, 16'd0);
    chk("t6_no_bad", {15'd0, bus.pin_bad}, 16'd0);
    bus.card_present = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) begin
      enter_pin(4'd0, 4'd0, 4'd0, 4'd0);
      tick(1);
    end
    tick(50);
    chk("t6_locked", {15'd0, bus.pin_locked}, 16'd1);
    reset = 1'b0;
    #2;
    chk_all_zero("t6_async");
    bus.card_present = 1'b0;
    #2;
    reset = 1'b1;
    tick(1);
    chk_all_zero("t6_after");
    bus.card_present = 1'b1;
    tick(1);
    chk("t6_recover", {15'd0, bus.busy}, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pin_entry_controller.md
Name: pin_entry_controller

Overview:
Upstream stage of the ATM transaction controller. Collects keypad digits, compares the entered PIN against the stored PIN, counts failed attempts and enforces a timed card lockout after the maximum number of failures. Delivers a clean pin_valid level plus pin_locked and attempt status, which the transaction controller consumes instead of raw PIN inputs.

Parameters:
PIN_DIGITS, 4, number of BCD digits in a PIN (1..4)
STORED_PIN, 16'h1234, stored PIN, one BCD nibble per digit, first digit in the most significant used nibble
MAX_ATTEMPTS, 3, failed attempts that trigger lockout (1..3)
LOCK_CYCLES, 1000, clock cycles a lockout lasts
TIMEOUT_CYCLES, 200, inactivity cycles in COLLECT before the buffer is discarded

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  asynchronous, active-low reset
card_present  input  1  level, card in slot
key_valid  input  1  one-cycle strobe, key_code valid
key_code  input  4  0-9 = digit, 4'hA = clear, 4'hB = enter, 4'hC-4'hF ignored
pin_valid  output  1  level, high while state is GRANT
pin_ok  output  1  one-cycle pulse on a successful check
pin_bad  output  1  one-cycle pulse on a failed check
pin_locked  output  1  level, high while state is LOCKED
attempt  output  2  failed attempts so far in this session
digit_count  output  3  digits currently buffered (0..PIN_DIGITS)
busy  output  1  high in COLLECT and CHECK

Behaviour:
- Reset, asynchronous and active-low: state=IDLE; buffer, digit_count, attempt, timers = 0; all outputs 0.
- All outputs registered. Unsupported key codes never change state.
- IDLE: card_present=1 -> COLLECT with an empty buffer.
- COLLECT:
  - Digit with digit_count<PIN_DIGITS: shift left into the buffer, digit_count+1.
  - Digit with digit_count=PIN_DIGITS: ignored.
  - Clear: buffer=0, digit_count=0.
  - Enter with digit_count<PIN_DIGITS: ignored, not an attempt.
  - Enter with digit_count=PIN_DIGITS: -> CHECK.
  - Inactivity timer reloads on every key_valid. On expiry: buffer and digit_count clear, stay in COLLECT, attempt unchanged.
- CHECK, always one cycle:
  - Buffer == STORED_PIN: -> GRANT, pin_ok pulse, attempt=0.
  - Otherwise: attempt+1 and pin_bad pulse.
    - New attempt=MAX_ATTEMPTS: -> LOCKED.
    - Else: -> COLLECT with buffer cleared.
- Latency: enter sampled at edge k -> CHECK after k -> pin_ok or pin_bad high for exactly the cycle after edge k+1, in the same cycle as pin_valid or pin_locked rises.
- GRANT: pin_valid=1 and all keys ignored. card_present=0 -> IDLE, attempt=0.
- LOCKED: pin_locked=1, keys ignored, lock counter counts LOCK_CYCLES.
  - Card removal does not end the lockout.
  - On expiry: -> IDLE, attempt=0, pin_locked=0. If the card is still present, the next cycle re-enters COLLECT.
- card_present=0 in COLLECT or CHECK: -> IDLE next edge, buffer and attempt clear, no pin_ok or pin_bad pulse. Card removal takes priority over a simultaneous key.
- Buffer digits are stored unpacked. Comparison uses only the low 4*PIN_DIGITS bits.
- Reset asserted mid-lockout or mid-entry: immediate return to reset values.

Test Plan:
1. Card in, keys 1,2,3,4, enter -> pin_ok pulse 2 cycles after enter, pin_valid=1, attempt=0. Card out -> IDLE, pin_valid=0.
2. 1,2,3,5 enter then 1,2,3,4 enter -> first pin_bad with attempt=1, then pin_ok with attempt=0.
3. Three wrong PINs -> pin_bad each time, attempt 1,2,3, pin_locked=1 on the third. Remove and reinsert the card -> stays LOCKED until 1000 cycles elapse, then pin_locked=0.
4. Keys 1,2, clear, 1,2,3,4,9, enter -> 9 ignored, digit_count=4, pin_ok. Enter after only 3 digits -> no pulse, stays COLLECT.
5. Keys 1,2 then 200 idle cycles -> digit_count=0, attempt unchanged.
6. Card removed in the same cycle as enter, and reset asserted mid-lockout -> IDLE with no pulses; reset values on all outputs.
